// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths, FSM state type and normalisation for the waveform combiner.
package synth_pkg;

  localparam int DATA_W     = 8;
  localparam int NUM_VOICES = 4;
  localparam int ACC_W      = 10;
  localparam int CNT_W      = 3;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    NORM
  } state_e;

  // Three or four voices share the same >>2 so the divider stays a pure shift.
  function automatic logic [DATA_W-1:0] normalise(input logic [ACC_W-1:0] sum,
                                                  input logic [CNT_W-1:0] count);
    logic [ACC_W-1:0] scaled;
    case (count)
      3'd0:    scaled = '0;
      3'd1:    scaled = sum;
      3'd2:    scaled = sum >> 1;
      default: scaled = sum >> 2;
    endcase
    if (|scaled[ACC_W-1:DATA_W]) begin
      return {DATA_W{1'b1}};
    end
    return scaled[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/waveform_combiner.sv
// rtl/waveform_combiner.sv - sums enabled voices one per cycle and normalises by active voice count.
module waveform_combiner
  import synth_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [DATA_W-1:0] wave0,
  input  logic [DATA_W-1:0] wave1,
  input  logic [DATA_W-1:0] wave2,
  input  logic [DATA_W-1:0] wave3,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic [DATA_W-1:0] comb_waveform,
  output logic              ready,
  output logic              busy,
  output logic              overrun
);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     wave_q [NUM_VOICES];
  logic [DATA_W-1:0]     wave_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     comb_q, comb_d;
  logic                  ready_q, ready_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    wave_d    = wave_q;
    en_d      = en_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    comb_d    = comb_q;
    ready_d   = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (strobe) begin
          wave_d[0] = wave0;
          wave_d[1] = wave1;
          wave_d[2] = wave2;
          wave_d[3] = wave3;
          en_d      = voice_en;
          acc_d     = '0;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        // A strobe here is dropped, not queued; only the overrun flag records it.
        overrun_d = strobe;
        if (en_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(wave_q[idx_q]);
          cnt_d = cnt_q + CNT_W'(1);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        overrun_d = strobe;
        comb_d    = normalise(acc_q, cnt_q);
        ready_d   = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < NUM_VOICES; i++) begin
        wave_q[i] <= '0;
      end
      en_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      comb_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        wave_q[i] <= wave_d[i];
      end
      en_q      <= en_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      comb_q    <= comb_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign comb_waveform = comb_q;
  assign ready         = ready_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_waveform_combiner.sv
// tb/tb_waveform_combiner.sv - directed vectors with hand-computed results for waveform_combiner.
module tb_waveform_combiner;

  logic       clk;
  logic       rst;
  logic       strobe;
  logic [7:0] wave0, wave1, wave2, wave3;
  logic [3:0] voice_en;
  logic [7:0] comb_waveform;
  logic       ready;
  logic       busy;
  logic       overrun;

  int checks;
  int errors;

  waveform_combiner dut (
    .clk           (clk),
    .rst           (rst),
    .strobe        (strobe),
    .wave0         (wave0),
    .wave1         (wave1),
    .wave2         (wave2),
    .wave3         (wave3),
    .voice_en      (voice_en),
    .comb_waveform (comb_waveform),
    .ready         (ready),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [3:0] en, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
    voice_en = en;
    wave0    = w0;
    wave1    = w1;
    wave2    = w2;
    wave3    = w3;
  endtask

  // Inputs are inverted right after the accepting edge, so every result also proves latching.
  task automatic run_op(input string name, input logic [3:0] en, input logic [7:0] w0,
                        input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3,
                        input logic [7:0] exp);
    set_inputs(en, w0, w1, w2, w3);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    set_inputs(~en, ~w0, ~w1, ~w2, ~w3);
    check({name, "_busy_e0"}, 32'(busy), 1);
    check({name, "_ready_e0"}, 32'(ready), 0);
    repeat (4) tick();
    check({name, "_ready_e4"}, 32'(ready), 0);
    check({name, "_busy_e4"}, 32'(busy), 1);
    tick();
    check({name, "_ready_e5"}, 32'(ready), 1);
    check({name, "_comb_e5"}, 32'(comb_waveform), 32'(exp));
    check({name, "_busy_e5"}, 32'(busy), 0);
    tick();
    check({name, "_ready_e6"}, 32'(ready), 0);
    check({name, "_comb_hold"}, 32'(comb_waveform), 32'(exp));
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    strobe = 1'b0;
    set_inputs(4'h0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (2) tick();
    check("rst_comb", 32'(comb_waveform), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    tick();

    run_op("all255", 4'b1111, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    run_op("one", 4'b0001, 8'd200, 8'd255, 8'd255, 8'd255, 8'd200);
    run_op("two", 4'b0011, 8'd100, 8'd51, 8'd255, 8'd255, 8'd75);
    run_op("three", 4'b0111, 8'd255, 8'd255, 8'd255, 8'd255, 8'd191);
    run_op("none", 4'b0000, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0);

    // Strobe during ACCUM is dropped; a strobe at E6 starts the next result.
    set_inputs(4'b0011, 8'd100, 8'd51, 8'd255, 8'd255);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    strobe = 1'b1;
    set_inputs(4'b1111, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("ovr_pulse", 32'(overrun), 1);
    strobe = 1'b0;
    tick();
    check("ovr_clear", 32'(overrun), 0);
    tick();
    check("ovr_ready_e4", 32'(ready), 0);
    tick();
    check("ovr_ready_e5", 32'(ready), 1);
    check("ovr_comb_e5", 32'(comb_waveform), 75);
    set_inputs(4'b0001, 8'd200, 8'd0, 8'd0, 8'd0);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    check("e6_busy", 32'(busy), 1);
    check("e6_ready", 32'(ready), 0);
    check("e6_overrun", 32'(overrun), 0);
    repeat (4) tick();
    check("e6_ready_e4", 32'(ready), 0);
    tick();
    check("e6_ready_e5", 32'(ready), 1);
    check("e6_comb", 32'(comb_waveform), 200);
    tick();

    // Reset at E3 aborts the operation with no ready pulse.
    set_inputs(4'b1111, 8'd255, 8'd255, 8'd255, 8'd255);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_comb", 32'(comb_waveform), 0);
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    seen = 0;
    repeat (6) begin
      tick();
      if (ready) seen++;
    end
    check("mid_rst_no_ready", 32'(seen), 0);
    run_op("after_rst", 4'b0111, 8'd255, 8'd255, 8'd255, 8'd255, 8'd191);

    // Held strobe restarts at every IDLE edge: ready at E5 and E11.
    set_inputs(4'b0001, 8'd37, 8'd0, 8'd0, 8'd0);
    strobe = 1'b1;
    tick();
    check("held_busy_e0", 32'(busy), 1);
    tick();
    check("held_overrun_e1", 32'(overrun), 1);
    repeat (4) tick();
    check("held_ready_e5", 32'(ready), 1);
    check("held_comb_e5", 32'(comb_waveform), 37);
    tick();
    check("held_busy_e6", 32'(busy), 1);
    check("held_ready_e6", 32'(ready), 0);
    repeat (4) tick();
    check("held_ready_e10", 32'(ready), 0);
    tick();
    check("held_ready_e11", 32'(ready), 1);
    check("held_comb_e11", 32'(comb_waveform), 37);
    strobe = 1'b0;
    repeat (8) tick();
    check("held_idle_end", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_combiner.md
WAVEFORM_COMBINER -- requirements
Module: waveform_combiner

Interface
REQ-001 The block SHALL have no parameters; widths and voice count come from the shared package (DATA_W = 8, NUM_VOICES = 4).
REQ-002 clk  input  1  system sample-rate clock; sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 strobe  input  1  one-cycle pulse requesting a new combined sample.
REQ-005 wave0..wave3  input  8 each  unsigned voice samples (0..255).
REQ-006 voice_en  input  4  active-voice mask; bit i enables wave<i>.
REQ-007 comb_waveform  output  8  registered combined sample; feeds the PWM stage.
REQ-008 ready  output  1  one-cycle pulse; comb_waveform is new and valid in the same cycle.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 overrun  output  1  one-cycle pulse when a strobe is dropped.

Function
REQ-011 The FSM SHALL have three states: IDLE, ACCUM, NORM.
REQ-012 On a rising edge in IDLE with strobe=1, the block SHALL latch wave0..wave3 and voice_en, clear the 10-bit accumulator and the 3-bit voice count, set voice index to 0, and enter ACCUM.
REQ-013 Each edge in ACCUM SHALL add the latched wave<idx> to the accumulator and increment the voice count if latched voice_en[idx]=1; idx then increments.
REQ-014 On the ACCUM edge with idx=3, the FSM SHALL move to NORM after performing that addition.
REQ-015 The NORM edge SHALL compute the normalised value, register it into comb_waveform, assert ready for exactly one cycle, and return to IDLE.
REQ-016 Normalisation by voice count: 0 -> 0; 1 -> sum; 2 -> sum>>1; 3 or 4 -> sum>>2. The result SHALL saturate at 255.
REQ-017 Latency: ready SHALL be high in the cycle following the 5th rising edge after the strobe-accepting edge (edge E0 accepts strobe; the result is registered at E5).
REQ-018 comb_waveform SHALL hold its value between ready pulses.
REQ-019 Inputs changing after the accepting edge SHALL NOT affect the result in flight.
REQ-020 A strobe sampled in ACCUM or NORM SHALL be ignored (not queued), SHALL NOT disturb the result in flight, and SHALL pulse overrun for one cycle.
REQ-021 A strobe is accepted again from the first edge where the state is IDLE (E6 onward).
REQ-022 A strobe that is held high continuously SHALL start a new combination at every IDLE edge, giving a period of 6 cycles.
REQ-023 The 10-bit accumulator SHALL NOT overflow (maximum sum 1020).

Reset
REQ-024 With rst=1 at an edge, the block SHALL set: state IDLE, comb_waveform 0, ready 0, overrun 0, busy 0, accumulator/count/idx/latched inputs 0.
REQ-025 Reset SHALL take priority over strobe in any state.
REQ-026 Reset mid-ACCUM or mid-NORM SHALL abort the operation without a ready pulse.

Structure
REQ-027 A shared package synth_pkg SHALL hold: DATA_W, NUM_VOICES, the state enum (IDLE, ACCUM, NORM), and the normalise function.
REQ-028 The block SHALL be a single module with no sub-modules; the voice mux, accumulator, FSM and output register SHALL be inline.

Verification
REQ-029 Bench case: all 4 voices enabled at 255, strobe -> 5 edges later ready=1, comb_waveform=255, busy high during E0..E5.
REQ-030 Bench case: voice_en=0001, wave0=200, others 255 -> comb_waveform=200; voice_en=0011, wave0=100, wave1=51 -> 75.
REQ-031 Bench case: voice_en=0111, all 255 -> 191; voice_en=0000 -> ready pulses with comb_waveform=0.
REQ-032 Bench case: strobe again at E2 -> overrun pulse one cycle later; single ready at E5 with the first result; a strobe at E6 is accepted.
REQ-033 Bench case: rst asserted at E3 of an operation -> no ready; all outputs 0 next cycle; a strobe after reset completes normally.
REQ-034 Bench case: change wave inputs at E1 -> the result reflects the values latched at E0.
